// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle main controller and the datapath.
// The controller is the master: it receives the opcode and memory-ready
// from the datapath and drives every enable and mux select back.
interface multicycle_ctrl_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            iord;
    logic            irwrite;
    logic            pcwrite;
    logic            branch;
    logic            branch_ne;
    logic            memwrite;
    logic            regwrite;
    logic            regdst;
    logic            memtoreg;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic [1:0]      pcsrc;
    logic [1:0]      aluop;
    logic            illegal_op;
    logic [3:0]      state;

    modport master (
        input  op, mem_ready,
        output iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite,
               regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath. Every output is a
// function of the state register only, except the FETCH write-enables (gated
// by mem_ready) and illegal_op (DECODE only, from the opcode).
module multicycle_ctrl #(
    parameter int OP_W          = 6,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_ctrl_if.master    bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    state_t r_state;
    state_t w_next;
    logic   w_illegal;
    logic   w_mr;

    // Without the handshake the memory is assumed single-cycle.
    assign w_mr = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // State register; async reset returns straight to FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // Next-state decode and illegal-opcode detection.
    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:   w_next = w_mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_BNE: begin
                        if (SUPPORT_BNE) w_next = S_BNE;
                        else             w_illegal = 1'b1;
                    end
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_illegal = 1'b1;
                endcase
            end
            // op comes live from the IR, which cannot change outside FETCH.
            S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_mr ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_mr ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Datapath controls, decoded from the current state.
    always_comb begin
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_ne  = 1'b0;
        bus.memwrite   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.aluop      = 2'b00;
        bus.illegal_op = w_illegal;
        bus.state      = r_state;
        case (r_state)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = w_mr;
                bus.pcwrite = w_mr;
            end
            S_DECODE:  bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQ: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            S_BNE: begin
                bus.alusrca   = 1'b1;
                bus.aluop     = 2'b01;
                bus.pcsrc     = 2'b01;
                bus.branch_ne = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
            S_JUMP: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: two controllers (bne supported / not) run the same
// directed instruction stream; expected per-cycle controls are queued by the
// stimulus and checked by a negedge monitor.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       illegal_op;
        logic [3:0] state;
    } ctl_t;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           J = 6'b000010, BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    ctl_t q1[$];
    ctl_t q0[$];
    ctl_t e1, a1, e0, a0;

    multicycle_ctrl_if #(.OP_W(6)) bus1 ();
    multicycle_ctrl_if #(.OP_W(6)) bus0 ();

    multicycle_ctrl #(.OP_W(6), .SUPPORT_BNE(1'b1), .MEM_HANDSHAKE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    multicycle_ctrl #(.OP_W(6), .SUPPORT_BNE(1'b0), .MEM_HANDSHAKE(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));

    always #5 clk = ~clk;

    // Expected controls for a state, from the state output table.
    function automatic ctl_t exp_ctl(input logic [3:0] s, input logic mr, input logic ill);
        ctl_t c = '0;
        c.state = s;
        c.illegal_op = ill;
        case (s)
            4'd0:  begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            4'd1:  c.alusrcb = 2'b11;
            4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd3:  c.iord = 1'b1;
            4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            4'd6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            4'd8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd10: c.regwrite = 1'b1;
            4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            4'd12: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch_ne = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t get1();
        ctl_t c;
        c.iord = bus1.iord; c.irwrite = bus1.irwrite; c.pcwrite = bus1.pcwrite;
        c.branch = bus1.branch; c.branch_ne = bus1.branch_ne; c.memwrite = bus1.memwrite;
        c.regwrite = bus1.regwrite; c.regdst = bus1.regdst; c.memtoreg = bus1.memtoreg;
        c.alusrca = bus1.alusrca; c.alusrcb = bus1.alusrcb; c.pcsrc = bus1.pcsrc;
        c.aluop = bus1.aluop; c.illegal_op = bus1.illegal_op; c.state = bus1.state;
        return c;
    endfunction

    function automatic ctl_t get0();
        ctl_t c;
        c.iord = bus0.iord; c.irwrite = bus0.irwrite; c.pcwrite = bus0.pcwrite;
        c.branch = bus0.branch; c.branch_ne = bus0.branch_ne; c.memwrite = bus0.memwrite;
        c.regwrite = bus0.regwrite; c.regdst = bus0.regdst; c.memtoreg = bus0.memtoreg;
        c.alusrca = bus0.alusrca; c.alusrcb = bus0.alusrcb; c.pcsrc = bus0.pcsrc;
        c.aluop = bus0.aluop; c.illegal_op = bus0.illegal_op; c.state = bus0.state;
        return c;
    endfunction

    // Monitor: one expected control word per cycle per controller.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            a1 = get1();
            total++;
            if (a1 !== e1) begin
                bad++;
                $display("FAIL ctl_bne1 cyc=%0d got=%h exp=%h", cyc, a1, e1);
            end
        end
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            a0 = get0();
            total++;
            if (a0 !== e0) begin
                bad++;
                $display("FAIL ctl_bne0 cyc=%0d got=%h exp=%h", cyc, a0, e0);
            end
        end
    end

    // One clock cycle: drive inputs, queue the expected controls.
    task automatic step(input logic [5:0] o, input logic m, input logic m0,
                        input logic [3:0] s1, input logic i1,
                        input logic [3:0] s0, input logic i0);
        bus1.op = o; bus0.op = o;
        bus1.mem_ready = m; bus0.mem_ready = m0;
        q1.push_back(exp_ctl(s1, m, i1));
        q0.push_back(exp_ctl(s0, m0, i0));
        @(posedge clk); #1;
    endtask

    task automatic s(input logic [5:0] o, input logic m, input logic [3:0] st, input logic ill);
        step(o, m, m, st, ill, st, ill);
    endtask

    initial begin
        bus1.op = LW; bus0.op = LW; bus1.mem_ready = 1'b1; bus0.mem_ready = 1'b1;
        @(posedge clk); #1;
        // Reset state is FETCH with gated enables.
        s(LW, 1, 0, 0);
        reset_n = 1'b1;
        // lw: 0,1,2,3,4
        s(LW, 1, 0, 0); s(LW, 1, 1, 0); s(LW, 1, 2, 0); s(LW, 1, 3, 0); s(LW, 1, 4, 0);
        // sw with three stall cycles in MEMWR
        s(SW, 1, 0, 0); s(SW, 1, 1, 0); s(SW, 1, 2, 0);
        s(SW, 0, 5, 0); s(SW, 0, 5, 0); s(SW, 0, 5, 0); s(SW, 1, 5, 0);
        // R-type then beq
        s(RT, 1, 0, 0); s(RT, 1, 1, 0); s(RT, 1, 6, 0); s(RT, 1, 7, 0);
        s(BEQ, 1, 0, 0); s(BEQ, 1, 1, 0); s(BEQ, 1, 8, 0);
        // bne: supported on dut1; illegal on dut0, which then stalls in FETCH to realign
        step(BNE, 1, 1, 0, 0, 0, 0);
        step(BNE, 1, 1, 1, 0, 1, 1);
        step(BNE, 1, 0, 12, 0, 0, 0);
        // illegal opcode, then jump
        s(BAD, 1, 0, 0); s(BAD, 1, 1, 1);
        s(J, 1, 0, 0); s(J, 1, 1, 0); s(J, 1, 11, 0);
        // addi
        s(ADDI, 1, 0, 0); s(ADDI, 1, 1, 0); s(ADDI, 1, 9, 0); s(ADDI, 1, 10, 0);
        // lw with FETCH and MEMRD stalls
        s(LW, 0, 0, 0); s(LW, 1, 0, 0); s(LW, 1, 1, 0); s(LW, 1, 2, 0);
        s(LW, 0, 3, 0); s(LW, 1, 3, 0); s(LW, 1, 4, 0);
        // sw stalled in MEMWR, then reset mid-cycle
        s(SW, 1, 0, 0); s(SW, 1, 1, 0); s(SW, 1, 2, 0); s(SW, 0, 5, 0);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus1.state !== 4'd0 || bus1.memwrite !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_bne1 got state=%0d memwrite=%b exp state=0 memwrite=0",
                     bus1.state, bus1.memwrite);
        end
        total++;
        if (bus0.state !== 4'd0 || bus0.memwrite !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_bne0 got state=%0d memwrite=%b exp state=0 memwrite=0",
                     bus0.state, bus0.memwrite);
        end
        bus1.mem_ready = 1'b1; bus0.mem_ready = 1'b1;
        q1.push_back(exp_ctl(4'd0, 1'b1, 1'b0));
        q0.push_back(exp_ctl(4'd0, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        s(RT, 1, 0, 0); s(RT, 1, 1, 0); s(RT, 1, 6, 0);
        @(posedge clk); #1;
        total++;
        if (q1.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got q1=%0d q0=%0d exp 0", q1.size(), q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle MIPS processor; successor to the single-cycle combinational main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects.
- Adds three capabilities: a memory-ready stall handshake, optional bne support, and illegal-opcode flagging.
- Sits between the instruction register opcode field and the multicycle datapath; the ALU decoder consumes aluop.

Parameters:
- OP_W, 6, opcode field width.
- SUPPORT_BNE, 1, 1 = bne (opcode 000101) decoded; 0 = treated as illegal.
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory access completes this cycle
- iord  out 1  memory address select (0 = PC, 1 = ALUOut)
- irwrite  out 1  instruction register load
- pcwrite  out 1  unconditional PC load
- branch  out 1  PC load if zero
- branch_ne  out 1  PC load if not zero
- memwrite  out 1  data memory write
- regwrite  out 1  register file write
- regdst  out 1  destination register: 1 = rd, 0 = rt
- memtoreg  out 1  writeback source: 1 = memory data, 0 = ALUOut
- alusrca  out 1  ALU A: 0 = PC, 1 = register A
- alusrcb  out 2  ALU B: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out 2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out 2  to ALU decoder: 00 = add, 01 = sub, 10 = funct
- illegal_op  out 1  one-cycle pulse on undecodable opcode
- state  out 4  current state encoding, for debug

Behaviour:
- Reset (async, reset_n=0): state=FETCH (0). All outputs are driven from state, so the reset values are the FETCH values. FETCH write-enables are gated by mem_ready; illegal_op=0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12. Encodings 13-15 go to FETCH.
- Outputs default to 0 unless listed for the state:
  - FETCH: alusrcb=01, irwrite=pcwrite=mem_ready (gated).
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNE: as BEQ but branch_ne=1, branch=0.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE dispatches on op:
    - lw(100011)/sw(101011) -> MEMADR
    - R-type(000000) -> EXECUTE
    - beq(000100) -> BEQ
    - bne(000101) -> BNE if SUPPORT_BNE, else illegal
    - addi(001000) -> ADDIEX
    - j(000010) -> JUMP
    - any other op -> FETCH, with illegal_op=1 for exactly that DECODE cycle
  - MEMADR -> MEMRD for lw, MEMWR for sw. op is sampled live; the IR is stable because irwrite=0 outside FETCH.
  - MEMRD -> MEMWB when mem_ready, else hold.
  - MEMWR -> FETCH when mem_ready, else hold; memwrite stays 1 throughout the hold.
  - MEMWB, ALUWB, ADDIWB, BEQ, BNE, JUMP -> FETCH.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle.
- Reset asserted mid-instruction: immediate return to FETCH, no further write strobes; memwrite drops asynchronously.
- Outputs must be glitch-free relative to state: no combinational path from op to any output except illegal_op (DECODE only) and the FETCH mem_ready gating.

Test Plan:
- Reset release, mem_ready=1, op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; irwrite=1 only in cycle 1.
- op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, iord=1 throughout, then FETCH.
- op=000000 then 000100 back-to-back -> EXECUTE aluop=10, ALUWB regdst=1; then BEQ branch=1, pcsrc=01, aluop=01, 3 cycles total.
- op=000101 with SUPPORT_BNE=1 -> state 12, branch_ne=1, branch=0. With SUPPORT_BNE=0 -> illegal_op pulse in DECODE, next state FETCH.
- op=111111 -> illegal_op=1 for one cycle, no regwrite/memwrite/pcwrite after FETCH. Then op=000010 -> JUMP pcsrc=10, pcwrite=1.
- reset_n pulled low mid-cycle while in MEMWR -> state=0 and memwrite=0 immediately, before the next clk edge.
